// File: rtl/sail_hex_stream_parser_pkg.sv
// Shared types and ASCII constants for the Sail hex literal stream parser.
// Build option SAIL_HEX_UPPERCASE_EN is consumed only by sail_hex_digit_decode.
package sail_hex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAW_0  = 3'd1,
    ST_SAW_X  = 3'd2,
    ST_DIGITS = 3'd3,
    ST_DONE   = 3'd4,
    ST_DRAIN  = 3'd5
  } state_t;

  localparam logic [7:0] CH_ZERO = 8'h30; // '0'
  localparam logic [7:0] CH_NINE = 8'h39; // '9'
  localparam logic [7:0] CH_X    = 8'h78; // 'x'
  localparam logic [7:0] CH_LA   = 8'h61; // 'a'
  localparam logic [7:0] CH_LF   = 8'h66; // 'f'
  localparam logic [7:0] CH_UA   = 8'h41; // 'A'
  localparam logic [7:0] CH_UF   = 8'h46; // 'F'

  // Width counter is wide enough for N+1 with N up to 1024, plus +4 headroom.
  localparam int WW = 11;

endpackage

// File: rtl/sail_hex_stream_parser_if.sv
// Character-in / result-out bus of the hex literal parser.
// Handshake: a character moves when in_valid && in_ready on a rising clk edge;
// a result is held while out_valid=1 and is consumed on the edge where
// out_ready=1. The master drives characters and out_ready; the slave (parser)
// drives in_ready and the result.
interface sail_hex_stream_parser_if #(parameter int N = 64);
  logic         in_valid;
  logic [7:0]   in_char;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic         out_ok;
  logic [N-1:0] out_bits;
  logic         out_ready;

  modport master (
    output in_valid, in_char, in_last, out_ready,
    input  in_ready, out_valid, out_ok, out_bits
  );

  modport slave (
    input  in_valid, in_char, in_last, out_ready,
    output in_ready, out_valid, out_ok, out_bits
  );
endinterface

// File: rtl/sail_hex_stream_parser_digit_decode.sv
// Combinational hex digit classifier.
// SAIL_HEX_UPPERCASE_EN: when defined, 'A'-'F' are also accepted as digits.
module sail_hex_digit_decode
  import sail_hex_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_digit_o,
  output logic [3:0] nibble_o,
  output logic [2:0] lead_width_o
);

  // Classify the character and compute its nibble value.
  always_comb begin
    is_digit_o = 1'b0;
    nibble_o   = 4'd0;
    if (char_i >= CH_ZERO && char_i <= CH_NINE) begin
      is_digit_o = 1'b1;
      nibble_o   = 4'(char_i - CH_ZERO);
    end else if (char_i >= CH_LA && char_i <= CH_LF) begin
      is_digit_o = 1'b1;
      nibble_o   = 4'(char_i - CH_LA + 8'd10);
    end
`ifdef SAIL_HEX_UPPERCASE_EN
    else if (char_i >= CH_UA && char_i <= CH_UF) begin
      is_digit_o = 1'b1;
      nibble_o   = 4'(char_i - CH_UA + 8'd10);
    end
`endif
  end

  // Significant bits contributed when this digit is the first non-zero one.
  always_comb begin
    lead_width_o = 3'd4;
    if (nibble_o == 4'd0)      lead_width_o = 3'd0;
    else if (nibble_o == 4'd1) lead_width_o = 3'd1;
    else if (nibble_o <= 4'd3) lead_width_o = 3'd2;
    else if (nibble_o <= 4'd7) lead_width_o = 3'd3;
  end

endmodule

// File: rtl/sail_hex_stream_parser.sv
// Streaming parser for Sail "0x..." hex literals into an N-bit vector.
// Build option SAIL_HEX_UPPERCASE_EN (handled in sail_hex_digit_decode).
module sail_hex_stream_parser
  import sail_hex_pkg::*;
#(
  parameter int N = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  sail_hex_stream_parser_if.slave   bus,
  output state_t                    state_o
);

  localparam logic [WW-1:0] W_MAX = WW'(N);
  localparam logic [WW-1:0] W_SAT = WW'(N + 1);

  state_t          state_q, state_d;
  logic [WW-1:0]   width_q, width_d;
  logic [N-1:0]    acc_q, acc_d;
  logic            ok_q, ok_d;

  logic            is_digit;
  logic [3:0]      nibble;
  logic [2:0]      lead_width;
  logic            fire;
  logic [WW-1:0]   w_calc;
  logic [WW-1:0]   width_nxt;
  logic [N-1:0]    acc_nxt;

  sail_hex_digit_decode u_decode (
    .char_i       (bus.in_char),
    .is_digit_o   (is_digit),
    .nibble_o     (nibble),
    .lead_width_o (lead_width)
  );

  assign fire = bus.in_valid && bus.in_ready;

  // Width and value after accepting the current digit; leading zeros keep width 0.
  always_comb begin
    w_calc    = (width_q == '0) ? WW'(lead_width) : width_q + WW'(4);
    width_nxt = (w_calc > W_SAT) ? W_SAT : w_calc;
    acc_nxt   = N'({acc_q, nibble});
  end

  // Next-state and datapath update for the literal grammar.
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    acc_d   = acc_q;
    ok_d    = ok_q;
    case (state_q)
      ST_IDLE: if (fire) begin
        if (bus.in_char == CH_ZERO && !bus.in_last) state_d = ST_SAW_0;
        else begin
          ok_d    = 1'b0;
          state_d = bus.in_last ? ST_DONE : ST_DRAIN;
        end
      end
      ST_SAW_0: if (fire) begin
        if (bus.in_char == CH_X && !bus.in_last) state_d = ST_SAW_X;
        else begin
          ok_d    = 1'b0;
          state_d = bus.in_last ? ST_DONE : ST_DRAIN;
        end
      end
      ST_SAW_X, ST_DIGITS: if (fire) begin
        if (is_digit) begin
          width_d = width_nxt;
          acc_d   = acc_nxt;
          if (bus.in_last) begin
            ok_d    = (width_nxt <= W_MAX);
            state_d = ST_DONE;
          end else begin
            state_d = ST_DIGITS;
          end
        end else begin
          ok_d    = 1'b0;
          state_d = bus.in_last ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: if (fire && bus.in_last) begin
        ok_d    = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: if (bus.out_ready) begin
        state_d = ST_IDLE;
        width_d = '0;
        acc_d   = '0;
        ok_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any same-cycle transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      width_q <= '0;
      acc_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      acc_q   <= acc_d;
      ok_q    <= ok_d;
    end
  end

  assign bus.in_ready  = (state_q != ST_DONE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_ok    = (state_q == ST_DONE) && ok_q;
  assign bus.out_bits  = ((state_q == ST_DONE) && ok_q) ? acc_q : '0;
  assign state_o       = state_q;

endmodule

// File: tb/tb_sail_hex_stream_parser.sv
// Bench for sail_hex_stream_parser: three instances (N=4, 8, 64) share one
// character stream; each result is checked against hand-computed values.
module tb_sail_hex_stream_parser;
  import sail_hex_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       in_valid, in_last, out_ready;
  logic [7:0] in_char;

  sail_hex_stream_parser_if #(.N(4))  bus4  ();
  sail_hex_stream_parser_if #(.N(8))  bus8  ();
  sail_hex_stream_parser_if #(.N(64)) bus64 ();
  state_t st4, st8, st64;

  assign bus4.in_valid  = in_valid;  assign bus4.in_char  = in_char;
  assign bus4.in_last   = in_last;   assign bus4.out_ready = out_ready;
  assign bus8.in_valid  = in_valid;  assign bus8.in_char  = in_char;
  assign bus8.in_last   = in_last;   assign bus8.out_ready = out_ready;
  assign bus64.in_valid = in_valid;  assign bus64.in_char = in_char;
  assign bus64.in_last  = in_last;   assign bus64.out_ready = out_ready;

  sail_hex_stream_parser #(.N(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4),  .state_o(st4));
  sail_hex_stream_parser #(.N(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8),  .state_o(st8));
  sail_hex_stream_parser #(.N(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64), .state_o(st64));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic send_char(input logic [7:0] c, input logic last);
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    check("in_ready4",  64'(bus4.in_ready),  64'd1);
    check("in_ready8",  64'(bus8.in_ready),  64'd1);
    check("in_ready64", 64'(bus64.in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_char  = 8'h00;
  endtask

  task automatic send_str(input string s, input logic mark_last);
    for (int i = 0; i < s.len(); i++)
      send_char(s[i], mark_last && (i == s.len() - 1));
  endtask

  // Check the held result of all three instances, one cycle after the last char.
  task automatic check_result(input string tag,
                              input logic ok4,  input logic [63:0] v4,
                              input logic ok8,  input logic [63:0] v8,
                              input logic ok64, input logic [63:0] v64);
    exp_q.push_back(v4); exp_q.push_back(v8); exp_q.push_back(v64);
    check({tag, ".valid4"},  64'(bus4.out_valid),  64'd1);
    check({tag, ".valid8"},  64'(bus8.out_valid),  64'd1);
    check({tag, ".valid64"}, 64'(bus64.out_valid), 64'd1);
    check({tag, ".ok4"},     64'(bus4.out_ok),     64'(ok4));
    check({tag, ".ok8"},     64'(bus8.out_ok),     64'(ok8));
    check({tag, ".ok64"},    64'(bus64.out_ok),    64'(ok64));
    check({tag, ".bits4"},   64'(bus4.out_bits),   exp_q.pop_front());
    check({tag, ".bits8"},   64'(bus8.out_bits),   exp_q.pop_front());
    check({tag, ".bits64"},  bus64.out_bits,       exp_q.pop_front());
    check({tag, ".inrdy64"}, 64'(bus64.in_ready),  64'd0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".idle4"},  64'(st4),  64'(ST_IDLE));
    check({tag, ".idle64"}, 64'(st64), 64'(ST_IDLE));
    check({tag, ".nvalid"}, 64'(bus8.out_valid), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_char = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst.state8", 64'(st8), 64'(ST_IDLE));
    check("rst.inrdy8", 64'(bus8.in_ready), 64'd1);
    check("rst.valid8", 64'(bus8.out_valid), 64'd0);
    check("rst.ok8",    64'(bus8.out_ok), 64'd0);
    check("rst.bits64", bus64.out_bits, 64'd0);

    send_str("0xff", 1'b1);
    check_result("ff", 1'b0, 64'h0, 1'b1, 64'hff, 1'b1, 64'hff);
    consume("ff");

    send_str("0x1ff", 1'b1);
    check_result("1ff", 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h1ff);
    consume("1ff");

    send_str("0x00007", 1'b1);
    check_result("00007", 1'b1, 64'h7, 1'b1, 64'h7, 1'b1, 64'h7);
    consume("00007");

    send_str("0x0", 1'b1);
    check_result("zero", 1'b1, 64'h0, 1'b1, 64'h0, 1'b1, 64'h0);
    consume("zero");

    send_str("0x8", 1'b1);
    check_result("eight", 1'b1, 64'h8, 1'b1, 64'h8, 1'b1, 64'h8);
    consume("eight");

    send_str("0x10", 1'b1);
    check_result("ten", 1'b0, 64'h0, 1'b1, 64'h10, 1'b1, 64'h10);
    consume("ten");

    send_str("0q12", 1'b1);
    check_result("drain", 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    consume("drain");

    send_str("0x", 1'b1);
    check_result("noDigits", 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    consume("noDigits");

    send_str("0X1", 1'b1);
    check_result("upperX", 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    consume("upperX");

    send_str("0x1g", 1'b1);
    check_result("badDigit", 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    consume("badDigit");

    send_str("0xAB", 1'b1);
`ifdef SAIL_HEX_UPPERCASE_EN
    check_result("upperAB", 1'b0, 64'h0, 1'b1, 64'hab, 1'b1, 64'hab);
`else
    check_result("upperAB", 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
`endif
    consume("upperAB");

    // Result held with out_ready low while a character is offered.
    send_str("0x3c", 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_char = 8'h7a; in_last = 1'b1;
      tick();
      check_result("hold", 1'b0, 64'h0, 1'b1, 64'h3c, 1'b1, 64'h3c);
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume("hold");

    // Reset mid-string, with a same-cycle transfer that must be discarded.
    send_str("0x1", 1'b0);
    reset = 1'b1; in_valid = 1'b1; in_char = 8'h35; in_last = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("midrst.state8", 64'(st8), 64'(ST_IDLE));
    check("midrst.valid8", 64'(bus8.out_valid), 64'd0);
    check("midrst.inrdy8", 64'(bus8.in_ready), 64'd1);
    send_str("0x2", 1'b1);
    check_result("afterRst", 1'b1, 64'h2, 1'b1, 64'h2, 1'b1, 64'h2);

    // Reset while holding a result in DONE.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("donerst.state64", 64'(st64), 64'(ST_IDLE));
    check("donerst.valid64", 64'(bus64.out_valid), 64'd0);
    check("donerst.bits64",  bus64.out_bits, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sail_hex_stream_parser.md
SAIL_HEX_STREAM_PARSER -- requirements
Module: sail_hex_stream_parser

Interface
REQ-001 SHALL have parameter N, default 64: bitvector width the parsed literal must fit into; legal range 1..1024.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: a character is offered on in_char.
REQ-005 SHALL have port in_char, input, 8: ASCII byte of the literal string, first character first.
REQ-006 SHALL have port in_last, input, 1: marks the final character of the string.
REQ-007 SHALL have port in_ready, output, 1: the parser accepts in_char this cycle.
REQ-008 SHALL have port out_valid, output, 1: a parse result is presented.
REQ-009 SHALL have port out_ok, output, 1: the string is a valid hex literal that fits in N bits.
REQ-010 SHALL have port out_bits, output, N: parsed value, zero-extended; all zeros when out_ok=0.
REQ-011 SHALL have port out_ready, input, 1: downstream consumes the result.

Function
REQ-012 SHALL transfer a character only when in_valid && in_ready.
REQ-013 SHALL run the FSM IDLE -> SAW_0 -> SAW_X -> DIGITS -> DONE, plus DRAIN for error recovery.
REQ-014 SHALL have IDLE accept '0' and go to SAW_0; any other character SHALL be an error.
REQ-015 SHALL have SAW_0 accept 'x' and go to SAW_X; any other character SHALL be an error.
REQ-016 SHALL accept hex digits '0'-'9' and 'a'-'f' in SAW_X and DIGITS and go to DIGITS; any other character SHALL be an error.
REQ-017 SHALL treat the end of the string (in_last) in IDLE, SAW_0 or SAW_X as an error. Example: "0x" is invalid.
REQ-018 SHALL leave leading zero digits out of the width count and the value.
REQ-019 SHALL compute significant width as follows. The first non-zero digit contributes 1 bit for '1', 2 bits for '2'-'3', 3 bits for '4'-'7' and 4 bits for '8'-'f'. Each later digit adds 4 bits.
REQ-020 SHALL keep the width counter saturating at N+1. Width > N SHALL be an error.
REQ-021 SHALL accumulate the value as value = (value << 4) | nibble, truncated to N bits.
REQ-022 SHALL accept an all-zero literal (e.g. "0x000") as ok with value 0.
REQ-023 SHALL handle an error on a character without in_last by entering DRAIN. DRAIN SHALL keep in_ready=1 and discard characters until in_last, then go to DONE with out_ok=0.
REQ-024 SHALL handle an error on a character with in_last by going directly to DONE with out_ok=0.
REQ-025 SHALL assert out_valid in the cycle after the in_last character transfers (latency 1).
REQ-026 SHALL in DONE hold out_valid, out_ok and out_bits stable, with in_ready=0, until out_ready=1. It SHALL then return to IDLE on that edge.
REQ-027 SHALL drive in_ready=1 in IDLE, SAW_0, SAW_X, DIGITS and DRAIN.

Reset
REQ-028 SHALL on reset force IDLE, in_ready=1, out_valid=0, out_ok=0, out_bits=0, and clear the width counter and accumulator.
REQ-029 SHALL make reset asserted mid-string or in DONE discard all partial and held results. It SHALL have priority over any same-cycle transfer.

Configuration
REQ-030 SHALL, when SAIL_HEX_UPPERCASE_EN is defined, also accept 'A'-'F' as digits 10-15 with the widths of REQ-019.
REQ-031 SHALL, when SAIL_HEX_UPPERCASE_EN is undefined, treat 'A'-'F' as errors. The prefix 'X' SHALL remain an error in both builds.

Structure
REQ-032 SHALL place the FSM state enum and ASCII constants ('0', 'x', 'a', 'f', 'A', 'F') in the shared package sail_hex_pkg.
REQ-033 SHALL contain one combinational sub-module, sail_hex_digit_decode: char in; is_digit, nibble[3:0] and lead_width[2:0] out. The SAIL_HEX_UPPERCASE_EN build option SHALL be handled only inside this sub-module.

Verification
REQ-034 SHALL cover: N=8, "0xff" streamed back-to-back -> out_valid one cycle after 'f'(last), out_ok=1, out_bits=8'hff.
REQ-035 SHALL cover: N=8, "0x1ff" -> width 9 > 8 -> out_ok=0, out_bits=0.
REQ-036 SHALL cover: N=4, "0x00007" -> out_ok=1, out_bits=4'h7. Also N=4, "0x0" -> out_ok=1, out_bits=0.
REQ-037 SHALL cover: N=64, "0q12" -> DRAIN absorbs '1' and '2'(last) with in_ready=1 -> out_ok=0. Also "0x" -> out_ok=0.
REQ-038 SHALL cover: "0xAB" -> ok with value 8'hab if SAIL_HEX_UPPERCASE_EN is defined, else out_ok=0.
REQ-039 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0. Also reset pulsed after "0x1" -> IDLE, then "0x2" parses to 2.
